// File: rtl/clk_reset_sequencer.sv
// Sequenced reset generator: releases peripherals after a stable PLL lock, then the core,
// and re-enters reset on lock loss or a filtered board-button request.
module clk_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 1024,
    parameter int CORE_DELAY  = 16,
    parameter int BTN_FILTER  = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pll_lock,
    input  logic       btn_rstn,
    input  logic       clr_status,
    output logic       periph_rstn,
    output logic       core_rstn,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] lock_loss_cnt
);
    localparam int CNT_MAX = (LOCK_STABLE > CORE_DELAY) ? LOCK_STABLE : CORE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BTN_W   = $clog2(BTN_FILTER + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);
    localparam logic [BTN_W-1:0] BTN_FULL    = BTN_W'(BTN_FILTER);

    localparam logic [2:0] ST_HOLD   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STABLE = 3'd2;
    localparam logic [2:0] ST_PERIPH = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

    logic [SYNC_STAGES-1:0] lock_sync_r;
    logic [SYNC_STAGES-1:0] btn_sync_r;
    logic                   lock_s;
    logic                   btn_s;
    logic [BTN_W-1:0]       btn_cnt_r;
    logic                   btn_req_s;
    logic [2:0]             state_r;
    logic [2:0]             state_nx_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nx_s;
    logic                   loss_evt_s;

    assign lock_s    = lock_sync_r[SYNC_STAGES-1];
    assign btn_s     = btn_sync_r[SYNC_STAGES-1];
    assign btn_req_s = (btn_cnt_r == BTN_FULL);

    // Input synchronisers; the button chain idles released (high).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_sync_r <= '0;
            btn_sync_r  <= '1;
        end else begin
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], pll_lock};
            btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], btn_rstn};
        end
    end

    // Button low-time filter, saturating at the acceptance threshold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_cnt_r <= '0;
        end else if (btn_s) begin
            btn_cnt_r <= '0;
        end else if (btn_cnt_r != BTN_FULL) begin
            btn_cnt_r <= btn_cnt_r + BTN_W'(1);
        end else begin
            btn_cnt_r <= btn_cnt_r;
        end
    end

    // Next-state and counter decode; lock loss outranks a button request.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        loss_evt_s = 1'b0;
        case (state_r)
            ST_HOLD: begin
                state_nx_s = ST_WAIT;
                cnt_nx_s   = '0;
            end
            ST_WAIT: begin
                cnt_nx_s = '0;
                if (lock_s && !btn_req_s) begin
                    state_nx_s = ST_STABLE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_STABLE: begin
                if (!lock_s || btn_req_s) begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = '0;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nx_s = ST_PERIPH;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PERIPH: begin
                if (!lock_s) begin
                    state_nx_s = ST_HOLD;
                    cnt_nx_s   = '0;
                    loss_evt_s = 1'b1;
                end else if (btn_req_s) begin
                    state_nx_s = ST_HOLD;
                    cnt_nx_s   = '0;
                end else if (cnt_r == CORE_LAST) begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_nx_s = '0;
                if (!lock_s) begin
                    state_nx_s = ST_HOLD;
                    loss_evt_s = 1'b1;
                end else if (btn_req_s) begin
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_HOLD;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State and sequencing counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_HOLD;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Reset outputs decoded from next state, so assertion lands on the edge entering HOLD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            periph_rstn <= 1'b0;
            core_rstn   <= 1'b0;
            ready       <= 1'b0;
        end else begin
            periph_rstn <= (state_nx_s == ST_PERIPH) || (state_nx_s == ST_RUN);
            core_rstn   <= (state_nx_s == ST_RUN);
            ready       <= (state_nx_s == ST_RUN);
        end
    end

    // Sticky lock-loss status; an event in the clear cycle survives as a count of one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_lost     <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else if (loss_evt_s) begin
            lock_lost <= 1'b1;
            if (clr_status) begin
                lock_loss_cnt <= 8'd1;
            end else if (lock_loss_cnt == 8'hFF) begin
                lock_loss_cnt <= 8'hFF;
            end else begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end else if (clr_status) begin
            lock_lost     <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            lock_lost     <= lock_lost;
            lock_loss_cnt <= lock_loss_cnt;
        end
    end

endmodule

// File: doc/clk_reset_sequencer.md
Name: clk_reset_sequencer

Overview:
- Sits directly downstream of the fabric clock-conditioning block.
- Clocked by the conditioned global clock; consumes the asynchronous PLL lock indication and the board reset button.
- Generates sequenced, synchronously deasserted resets: peripherals first, then the RudolV core.
- Detects PLL lock loss and re-enters the reset sequence, keeping a sticky status flag and an event counter for debug.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser (lock and button); legal values 2..4.
- LOCK_STABLE, 1024, consecutive clk cycles the synchronised lock must stay high before peripherals are released; legal values 1..2^20.
- CORE_DELAY, 16, clk cycles from peripheral release to core release; legal values 1..2^16.
- BTN_FILTER, 8, consecutive clk cycles the synchronised button must stay low before it is accepted as a reset request; legal values 1..256.

Ports:
- clk, input, 1, conditioned global clock.
- rstn, input, 1, asynchronous active-low reset.
- pll_lock, input, 1, asynchronous PLL lock indication.
- btn_rstn, input, 1, asynchronous board reset button, active low.
- periph_rstn, output, 1, peripheral reset, active low.
- core_rstn, output, 1, core reset, active low.
- ready, output, 1, high while in RUN.
- lock_lost, output, 1, sticky flag: lock dropped while in PERIPH or RUN.
- lock_loss_cnt, output, 8, saturating count of lock-loss events.
- clr_status, input, 1, synchronous pulse that clears lock_lost and lock_loss_cnt.

Behaviour:
- Async reset (rstn=0): all flops clear immediately.
  - State=HOLD; periph_rstn=0, core_rstn=0, ready=0, lock_lost=0, lock_loss_cnt=0.
  - Synchroniser chains reset to 0 (lock) and 1 (button).
- Synchronisers: plain SYNC_STAGES flop chains; lock_s and btn_s are the last stage.
- Button filter:
  - The counter increments while btn_s=0 and clears when btn_s=1.
  - btn_req asserts when the counter reaches BTN_FILTER and holds while btn_s stays low; the counter saturates.
- States and transitions:
  - HOLD: both resets asserted. Next cycle goes to WAIT.
  - WAIT: both resets asserted; cnt=0. Goes to STABLE when lock_s=1 and btn_req=0.
  - STABLE:
    - cnt increments each cycle while lock_s=1.
    - If lock_s=0 or btn_req=1, go to WAIT and clear cnt.
    - When cnt==LOCK_STABLE-1, go to PERIPH and clear cnt.
  - PERIPH: periph_rstn=1, core_rstn=0, cnt increments. When cnt==CORE_DELAY-1, go to RUN.
  - RUN: periph_rstn=1, core_rstn=1, ready=1.
- Exits from PERIPH and RUN (lock loss has priority over btn_req when both occur in the same cycle):
  - lock_s=0: go to HOLD; set lock_lost; increment lock_loss_cnt, saturating at 255.
  - btn_req=1 (lock_s=1): go to HOLD with no status update.
- Outputs are registered, decoded from the next-state value.
  - Asserting edges: both resets fall in the same clk edge that enters HOLD.
  - Deassertion is always synchronous to clk.
  - core_rstn is never 1 while periph_rstn is 0.
- Latency, from the first cycle lock_s=1 in WAIT:
  - periph_rstn rises after LOCK_STABLE+1 cycles.
  - core_rstn rises CORE_DELAY cycles after periph_rstn.
  - Add SYNC_STAGES cycles to both figures when measuring from pll_lock.
- clr_status in the same cycle as a lock-loss event: the event wins, so lock_lost=1 and lock_loss_cnt=1 if it was 0.
- Glitches on pll_lock shorter than one cycle may or may not be captured. Any captured low restarts stability counting.
- Counter widths: cnt uses $clog2(max(LOCK_STABLE, CORE_DELAY))+1 bits. No wrap is possible because every compare terminates counting.

Test Plan:
1. rstn low 5 cycles, then high; pll_lock high at cycle 10 (defaults) -> periph_rstn rises at cycle 10+2+1025; core_rstn rises 16 cycles later; ready=1 from then on.
2. pll_lock drops for 3 cycles at STABLE count 500 -> back to WAIT; full 1024-cycle count restarts; lock_lost stays 0.
3. pll_lock drops in RUN -> both resets low within SYNC_STAGES+1 cycles; lock_lost=1, lock_loss_cnt=1; full sequence replays after relock.
4. btn_rstn low for 5 cycles -> ignored. btn_rstn low for 20 cycles in RUN -> resets asserted after 2+8+1 cycles; held until button release; then the sequence restarts; lock_lost unchanged.
5. Force 300 lock-loss events -> lock_loss_cnt saturates at 255. clr_status pulse -> count=0, lock_lost=0. clr_status coinciding with a loss -> count=1.
6. rstn asserted mid-PERIPH -> all outputs at reset values in the same cycle (asynchronously); after release, the sequence restarts from HOLD.
